// File: rtl/rps_pkg.sv
// Shared definitions for the rock-paper-scissors game.
// Holds the BCD encoder state type, the BCD nibble width, the player-choice
// encodings and a small helper for the double-dabble correction step.
package rps_pkg;

    // Encoder sequencing states: idle, shifting the user score,
    // shifting the computer score, one-cycle completion.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT_U = 2'd1,
        SHIFT_C = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int BCD_NIBBLE_W = 4;

    // Player / computer choice encodings used by the round logic.
    localparam logic [1:0] ROCK    = 2'b00;
    localparam logic [1:0] SCISSOR = 2'b01;
    localparam logic [1:0] PAPER   = 2'b10;

    // Double-dabble correction: a digit of 5 or more would become 10 or more
    // after doubling, so pre-add 3 to make the shift carry into the next digit.
    function automatic logic [BCD_NIBBLE_W-1:0] add3_if_ge5(
        input logic [BCD_NIBBLE_W-1:0] nibble
    );
        if (nibble >= 4'd5) begin
            return nibble + 4'd3;
        end
        return nibble;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration.
// Input/output vector layout is {BCD digits, binary remainder}; every BCD
// nibble is corrected independently (no carry between nibbles), then the
// whole vector is shifted left by one bit.
module bcd_dabble_step
    import rps_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
)
(
    input  logic [BCD_NIBBLE_W*DIGITS+WIDTH-1:0] din,
    output logic [BCD_NIBBLE_W*DIGITS+WIDTH-1:0] dout
);

    logic [BCD_NIBBLE_W*DIGITS+WIDTH-1:0] adjusted;

    // Per-nibble add-3 correction on the BCD field, then shift left by one.
    always_comb begin
        adjusted = din;
        for (int i = 0; i < DIGITS; i++) begin
            adjusted[WIDTH + BCD_NIBBLE_W*i +: BCD_NIBBLE_W] =
                add3_if_ge5(din[WIDTH + BCD_NIBBLE_W*i +: BCD_NIBBLE_W]);
        end
        dout = adjusted << 1;
    end

endmodule

// File: rtl/score_bcd_encoder.sv
// Sequential binary-to-BCD encoder for the two scoreboard scores.
// A single bcd_dabble_step is time-shared: WIDTH iterations for the user
// score, then WIDTH iterations for the computer score.
// Optional build macro: SCORE_AUTO_REFRESH_EN -- when defined, a change of
// either score input since the last conversion start also triggers a
// conversion, without needing a start pulse.
//
// Handshake: start (or the auto-refresh trigger) is sampled only while the
// encoder is IDLE (busy=0); requests while busy are dropped, not queued.
// busy is high in every non-IDLE state; done pulses for exactly one cycle in
// DONE, at which point both user_bcd and com_bcd hold the new results.
module score_bcd_encoder
    import rps_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
)
(
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic                           start,
    input  logic [WIDTH-1:0]               user_score,
    input  logic [WIDTH-1:0]               com_score,
    output logic [BCD_NIBBLE_W*DIGITS-1:0] user_bcd,
    output logic [BCD_NIBBLE_W*DIGITS-1:0] com_bcd,
    output logic                           busy,
    output logic                           done
);

    localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    state_t            state;
    state_t            next_state;
    logic [SR_W-1:0]   shift_reg;
    logic [SR_W-1:0]   step_out;
    logic [CNT_W-1:0]  count;
    logic [WIDTH-1:0]  com_shadow;
    logic              trigger;
    logic              last_shift;

    // The iteration that produces the final digits of the current operand.
    assign last_shift = (count == LAST_SHIFT);

`ifdef SCORE_AUTO_REFRESH_EN
    logic [WIDTH-1:0] last_user;
    logic [WIDTH-1:0] last_com;

    assign trigger = start | (user_score != last_user) | (com_score != last_com);

    // Remember the scores captured at the most recent conversion start.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            last_user <= '0;
            last_com  <= '0;
        end else if (state == IDLE && trigger) begin
            last_user <= user_score;
            last_com  <= com_score;
        end
    end
`else
    assign trigger = start;
`endif

    bcd_dabble_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_step (
        .din  (shift_reg),
        .dout (step_out)
    );

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (trigger) begin
                    next_state = SHIFT_U;
                end
            end
            SHIFT_U: begin
                if (last_shift) begin
                    next_state = SHIFT_C;
                end
            end
            SHIFT_C: begin
                if (last_shift) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shift sequencing and single-edge result update.
    // The user operand is loaded straight into the shift register at capture,
    // so only the computer operand needs a separate shadow copy.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            shift_reg  <= '0;
            count      <= '0;
            com_shadow <= '0;
            user_bcd   <= '0;
            com_bcd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        com_shadow <= com_score;
                        shift_reg  <= {{BCD_W{1'b0}}, user_score};
                        count      <= '0;
                    end
                end
                SHIFT_U: begin
                    if (last_shift) begin
                        user_bcd  <= step_out[SR_W-1 -: BCD_W];
                        shift_reg <= {{BCD_W{1'b0}}, com_shadow};
                        count     <= '0;
                    end else begin
                        shift_reg <= step_out;
                        count     <= count + CNT_W'(1);
                    end
                end
                SHIFT_C: begin
                    if (last_shift) begin
                        com_bcd   <= step_out[SR_W-1 -: BCD_W];
                        shift_reg <= '0;
                        count     <= '0;
                    end else begin
                        shift_reg <= step_out;
                        count     <= count + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_encoder.sv
// Testbench for score_bcd_encoder: directed timing scenarios plus randomized
// conversions; a monitor pops expected results at every done pulse.
module tb_score_bcd_encoder;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  user_score = 8'd0;
    logic [7:0]  com_score = 8'd0;
    logic [11:0] user_bcd;
    logic [11:0] com_bcd;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [23:0] exp_q[$];
    int          done_times[$];
    logic [23:0] mon_e;
    logic [11:0] cur_u = 12'h000;
    logic [11:0] cur_c = 12'h000;

    score_bcd_encoder #(.WIDTH(8), .DIGITS(3)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .start      (start),
        .user_score (user_score),
        .com_score  (com_score),
        .user_bcd   (user_bcd),
        .com_bcd    (com_bcd),
        .busy       (busy),
        .done       (done)
    );

    // clock / cycle counter
    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // reference model: decimal digits by plain arithmetic
    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every done pulse must match the oldest expected result
    always @(negedge CLOCK_50) begin
        if (done) begin
            done_cnt++;
            done_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected: got done=1 expected no result pending (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_user", 32'(user_bcd), 32'(mon_e[23:12]));
                check("result_com", 32'(com_bcd), 32'(mon_e[11:0]));
            end
        end
    end

    // wait until the DUT is idle; returns just after a rising edge
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLOCK_50);
        while (busy && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=1 after %0d cycles expected 0", n);
        end
        @(posedge CLOCK_50);
        #1;
    endtask

    // one conversion with cycle-by-cycle checks of busy/done/output hold;
    // poke=1 adds an ignored start pulse and random input changes mid-run
    task automatic timed_conv(input logic [7:0] u, input logic [7:0] c, input bit poke);
        int pk;
        int busy_cnt;
        logic [11:0] eu;
        logic [11:0] ec;
        eu = to_bcd(int'(u));
        ec = to_bcd(int'(c));
        wait_idle();
        user_score = u;
        com_score  = c;
        start      = 1'b1;
        @(posedge CLOCK_50);
        exp_q.push_back({eu, ec});
        #1;
        pk = poke ? int'($urandom_range(1, 15)) : -1;
        busy_cnt = 0;
        for (int k = 0; k <= 17; k++) begin
            if (k == pk) begin
                start      = 1'b1;
                user_score = 8'($urandom_range(0, 255));
                com_score  = 8'($urandom_range(0, 255));
            end else begin
                start = 1'b0;
            end
            @(negedge CLOCK_50);
            check("busy", 32'(busy), 32'(k < 17));
            check("done", 32'(done), 32'(k == 16));
            check("user_bcd", 32'(user_bcd), 32'((k >= 8) ? eu : cur_u));
            check("com_bcd", 32'(com_bcd), 32'((k >= 16) ? ec : cur_c));
            if (busy) busy_cnt++;
            @(posedge CLOCK_50);
            #1;
        end
        check("busy_len", 32'(busy_cnt), 32'd17);
        cur_u = eu;
        cur_c = ec;
    endtask

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int n0;
        // reset state
        reset = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_user", 32'(user_bcd), 32'h0);
        check("rst_com", 32'(com_bcd), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_done", 32'(done), 32'h0);
        end
        check("idle_user", 32'(user_bcd), 32'h0);
        check("idle_com", 32'(com_bcd), 32'h0);

`ifdef SCORE_AUTO_REFRESH_EN
        // score changes alone trigger conversions
        @(posedge CLOCK_50);
        #1;
        user_score = 8'd3;
        @(posedge CLOCK_50);
        exp_q.push_back({to_bcd(3), to_bcd(0)});
        repeat (20) @(posedge CLOCK_50);
        #1;
        d0 = done_cnt;
        user_score = 8'd4;
        @(posedge CLOCK_50);
        exp_q.push_back({to_bcd(4), to_bcd(0)});
        repeat (40) @(posedge CLOCK_50);
        #1;
        check("auto_done_count", 32'(done_cnt - d0), 32'd1);
        check("auto_user", 32'(user_bcd), 32'h004);
        n0 = 0;
`else
        // directed conversions, including both extremes
        timed_conv(8'd0, 8'd255, 1'b0);
        timed_conv(8'd99, 8'd100, 1'b0);
        timed_conv(8'd9, 8'd10, 1'b0);

        // inputs change mid-run and start pulses while busy
        wait_idle();
        user_score = 8'd42;
        com_score  = 8'd7;
        start      = 1'b1;
        @(posedge CLOCK_50);
        exp_q.push_back({to_bcd(42), to_bcd(7)});
        d0 = done_cnt;
        #1;
        start = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        user_score = 8'd200;
        com_score  = 8'd201;
        repeat (2) @(posedge CLOCK_50);
        #1;
        start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        repeat (20) @(posedge CLOCK_50);
        #1;
        check("midchange_done_count", 32'(done_cnt - d0), 32'd1);
        check("midchange_user", 32'(user_bcd), 32'h042);
        check("midchange_com", 32'(com_bcd), 32'h007);

        // start held high: back-to-back conversions every 18 cycles
        wait_idle();
        n0 = done_times.size();
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLOCK_50);
            exp_q.push_back({to_bcd(200), to_bcd(201)});
            if (i < 2) repeat (17) @(posedge CLOCK_50);
        end
        #1;
        start = 1'b0;
        wait_idle();
        check("held_count", 32'(done_times.size() - n0), 32'd3);
        if (done_times.size() >= n0 + 3) begin
            for (int i = 1; i < 3; i++) begin
                check("held_period", 32'(done_times[n0+i] - done_times[n0+i-1]), 32'd18);
            end
        end
        cur_u = 12'h200;
        cur_c = 12'h201;

        // reset in the middle of a conversion
        wait_idle();
        user_score = 8'd123;
        com_score  = 8'd45;
        start      = 1'b1;
        @(posedge CLOCK_50);
        exp_q.push_back({to_bcd(123), to_bcd(45)});
        #1;
        start = 1'b0;
        repeat (4) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_user", 32'(user_bcd), 32'h0);
        check("midrst_com", 32'(com_bcd), 32'h0);
        cur_u = 12'h000;
        cur_c = 12'h000;
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        timed_conv(8'd123, 8'd45, 1'b0);

        // randomized conversions with ignored mid-run stimulus
        for (int i = 0; i < 8; i++) begin
            timed_conv(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
        end
`endif

        wait_idle();
        repeat (5) @(posedge CLOCK_50);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_bcd_encoder.md
Name: score_bcd_encoder

Overview:
Sequential binary-to-BCD encoder for the rock-paper-scissors scoreboard. It is the producer side of the seven-segment digit path: it converts the two 8-bit score registers into decimal digit codes, and the existing hex nibble decoders turn those codes into segments. It uses a shift-and-add-3 (double-dabble) engine shared by the user score and the computer score, with a start/busy/done handshake to the round logic.

Parameters:
- WIDTH, 8: width of each binary score input.
- DIGITS, 3: number of BCD digits per score; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  conversion request, level-sampled in IDLE only.
- user_score  input  WIDTH  user score, binary.
- com_score  input  WIDTH  computer score, binary.
- user_bcd  output  4*DIGITS  user score BCD; [3:0] is the ones digit.
- com_bcd  output  4*DIGITS  computer score BCD; [3:0] is the ones digit.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when both BCD outputs have been updated.

Behaviour:
- Reset is asynchronous and active-low on reset; the clock is CLOCK_50.
- Reset values: user_bcd=0, com_bcd=0, busy=0, done=0, state=IDLE, all shadow and shift registers cleared. BCD 000 is the correct code for the reset score of 0.
- States: IDLE, SHIFT_U, SHIFT_C, DONE.
- IDLE:
  - On an edge with start=1, capture user_score and com_score into shadow registers, load the shift register with {BCD=0, user shadow}, clear the iteration counter, and go to SHIFT_U.
  - If start=0, stay in IDLE.
- SHIFT_U, each edge:
  - Every BCD nibble ≥5 gets +3.
  - Then the whole {BCD, binary} register shifts left by 1.
  - The counter increments.
- SHIFT_U exit: on the WIDTH-th shift edge, write the post-shift BCD field into user_bcd, reload the shift register with {0, com shadow}, reset the counter, and go to SHIFT_C.
- SHIFT_C: same shift rule. On the WIDTH-th edge, write com_bcd and go to DONE.
- DONE: done=1 for exactly this one cycle, then return to IDLE unconditionally.
- Timing (start sampled at edge E0):
  - user_bcd is valid after E(WIDTH).
  - com_bcd is valid after E(2*WIDTH).
  - done is high between E(2W) and E(2W+1).
  - busy is high for 2*WIDTH+1 cycles.
  - With start held high, conversions repeat every 2*WIDTH+2 cycles (18 at the defaults).
- user_bcd and com_bcd hold their last value between conversions. They never show partial results: each is updated in one edge only.
- Boundary conditions:
  - start while busy: ignored, not queued.
  - Score inputs changing mid-conversion: no effect; the shadow copies are used.
  - Score 255: converts to 2,5,5. Score 0: converts to 0,0,0.
  - Reset mid-conversion: immediately back to the reset values. Previous outputs are lost; the outputs read 000.
- The add-3 comparison is unsigned, per nibble, and applied before the shift. No carries propagate between nibbles during add-3.

Optional Feature:
Macro: SCORE_AUTO_REFRESH_EN
- Defined:
  - An internal trigger equals start OR (user_score != last_user OR com_score != last_com). last_user and last_com are the shadow values captured at the last conversion start and reset to 0.
  - A scoreboard update therefore converts without any start pulse.
  - The trigger is still sampled only in IDLE.
- Undefined: conversion occurs only on start, and the last_* registers are not synthesized.

Decomposition:
- Shared package rps_pkg holds:
  - the state typedef {IDLE, SHIFT_U, SHIFT_C, DONE};
  - localparam BCD_NIBBLE_W=4;
  - the choice encodings ROCK=2'b00, SCISSOR=2'b01, PAPER=2'b10, for the rest of the game.
- Sub-module bcd_dabble_step is combinational and parameterised by WIDTH and DIGITS. It takes the {BCD, binary} vector and returns the add-3-then-shift-left-by-1 result. It is instantiated once, and the state machine sequences it.

Test Plan:
- Reset release with start=0 for 20 cycles -> user_bcd=12'h000, com_bcd=12'h000, busy=0, done never asserted.
- user_score=8'd0, com_score=8'd255, start pulsed 1 cycle -> busy for 17 cycles, user_bcd=12'h000 after 8 edges, com_bcd=12'h255 after 16 edges, done pulse exactly 1 cycle.
- user_score=8'd99, com_score=8'd100 -> 12'h099, 12'h100. Then a second run with 8'd9 and 8'd10 -> 12'h009, 12'h010; the outputs hold the old values until the respective update edges.
- Start 8'd42/8'd7, then change the inputs to 8'd200/8'd201 at cycle 3 and pulse start at cycle 5 -> results 12'h042 and 12'h007 with a single done pulse; a start held high afterwards gives a period of 18 cycles.
- Assert reset at cycle 5 of a conversion of 8'd123 -> busy=0 and both outputs 0 immediately. A new start after release converts 8'd123 -> 12'h123.
- With SCORE_AUTO_REFRESH_EN defined and start=0, change user_score from 3 to 4 -> one conversion, user_bcd=12'h004, done pulses once, and no further conversions while the inputs are stable.
